decodificador_bcd_secuencial: RTL and testbench

- Parametrised binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Generalises the fixed 4-bit combinational decoder to any input width and any digit count.
- Adds valid/ready handshakes on input and output, an overflow flag and optional leading-zero blanking.
- Sits between binary datapath results and display/report logic.

---
 rtl/decodificador_bcd_secuencial.sv | 118 +++++++++++
 tb/tb_decodificador_bcd_secuencial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_bcd_secuencial.sv
// Binary-to-BCD converter (double dabble, one bit per clock); the result is valid W cycles after the input is accepted.
// There is no overlap: EntradaLista is high only when idle, and the result is held while SalidaValida waits for SalidaLista.
module decodificador_bcd_secuencial #(
  parameter int ANCHO_ENTRADA  = 8,
  parameter int NUM_DIGITOS    = 3,
  parameter int SUPRIMIR_CEROS = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ANCHO_ENTRADA-1:0]   DatoEntrada,
  input  logic                       EntradaValida,
  output logic                       EntradaLista,
  output logic [4*NUM_DIGITOS-1:0]   DatoSalida,
  output logic                       Desborde,
  output logic                       SalidaValida,
  input  logic                       SalidaLista
);

  localparam int ANCHO_BCD = 4 * NUM_DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_ENTRADA + 1);
  localparam logic [ANCHO_CNT-1:0] CNT_CARGA = ANCHO_CNT'(ANCHO_ENTRADA);
  localparam logic [ANCHO_CNT-1:0] CNT_UNO   = ANCHO_CNT'(1);

  localparam logic [1:0] INACTIVO = 2'd0;
  localparam logic [1:0] DESPLAZA = 2'd1;
  localparam logic [1:0] LISTO    = 2'd2;

  logic [1:0]               r_estado;
  logic [ANCHO_ENTRADA-1:0] r_bin;
  logic [ANCHO_BCD-1:0]     r_bcd;
  logic [ANCHO_BCD-1:0]     r_resultado;
  logic [ANCHO_CNT-1:0]     r_cnt;
  logic                     r_desborde;
  logic                     r_con_resultado;

  logic [ANCHO_BCD-1:0]     w_ajustado;
  logic [ANCHO_BCD-1:0]     w_bcd_desplazado;
  logic [ANCHO_ENTRADA-1:0] w_bin_desplazado;
  logic [ANCHO_BCD-1:0]     w_salida_suprimida;
  logic                     w_bit_salida;
  logic                     w_cero_arriba;
  logic                     w_acepta;
  logic                     w_ultimo;

  assign EntradaLista = (r_estado == INACTIVO);
  assign SalidaValida = (r_estado == LISTO);
  assign w_acepta     = EntradaLista && EntradaValida;
  assign w_ultimo     = (r_estado == DESPLAZA) && (r_cnt == CNT_UNO);

  // Add-3 correction per digit, done before the shift; the carry never leaves the digit.
  always_comb begin
    w_ajustado = r_bcd;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_ajustado[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bit_salida     = w_ajustado[ANCHO_BCD-1];
  assign w_bcd_desplazado = {w_ajustado[ANCHO_BCD-2:0], r_bin[ANCHO_ENTRADA-1]};
  assign w_bin_desplazado = r_bin << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado        <= INACTIVO;
      r_bin           <= '0;
      r_bcd           <= '0;
      r_resultado     <= '0;
      r_cnt           <= '0;
      r_desborde      <= 1'b0;
      r_con_resultado <= 1'b0;
    end else begin
      case (r_estado)
        INACTIVO: begin
          if (w_acepta) begin
            r_bin      <= DatoEntrada;
            r_bcd      <= '0;
            r_desborde <= 1'b0;
            r_cnt      <= CNT_CARGA;
            r_estado   <= DESPLAZA;
          end
        end
        DESPLAZA: begin
          r_bcd      <= w_bcd_desplazado;
          r_bin      <= w_bin_desplazado;
          r_desborde <= r_desborde | w_bit_salida;
          r_cnt      <= r_cnt - CNT_UNO;
          if (w_ultimo) begin
            r_resultado     <= w_bcd_desplazado;
            r_con_resultado <= 1'b1;
            r_estado        <= LISTO;
          end
        end
        LISTO: begin
          if (SalidaLista)
            r_estado <= INACTIVO;
        end
        default: r_estado <= INACTIVO;
      endcase
    end
  end

  // Blank zero digits above the most significant non-zero one; digit 0 always shows.
  always_comb begin
    w_salida_suprimida = r_resultado;
    w_cero_arriba      = 1'b1;
    for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
      if (w_cero_arriba && (r_resultado[4*i +: 4] == 4'd0))
        w_salida_suprimida[4*i +: 4] = 4'hF;
      else
        w_cero_arriba = 1'b0;
    end
  end

  assign DatoSalida = ((SUPRIMIR_CEROS != 0) && r_con_resultado) ? w_salida_suprimida : r_resultado;
  assign Desborde   = r_desborde;

endmodule

// File: tb/tb_decodificador_bcd_secuencial.sv
// Bench for four converter configurations: (8,3), (4,2), (8,2) and (8,3) with blanking.
// Uses a table of directed vectors, hand-written corner sequences and random values checked against an arithmetic model.
module tb_decodificador_bcd_secuencial;

  logic       clk;
  logic       rst_n;
  logic [7:0] din [4];
  logic       ev  [4];
  logic       sl  [4];
  logic [11:0] dout [4];
  logic       desb [4];
  logic       el   [4];
  logic       sv   [4];

  logic [11:0] q0, q3;
  logic [7:0]  q1, q2;
  logic        d0, d1, d2, d3, el0, el1, el2, el3, sv0, sv1, sv2, sv3;

  int total = 0;
  int bad   = 0;

  decodificador_bcd_secuencial #(.ANCHO_ENTRADA(8), .NUM_DIGITOS(3), .SUPRIMIR_CEROS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .DatoEntrada(din[0]), .EntradaValida(ev[0]), .EntradaLista(el0),
    .DatoSalida(q0), .Desborde(d0), .SalidaValida(sv0), .SalidaLista(sl[0]));
  decodificador_bcd_secuencial #(.ANCHO_ENTRADA(4), .NUM_DIGITOS(2), .SUPRIMIR_CEROS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .DatoEntrada(din[1][3:0]), .EntradaValida(ev[1]), .EntradaLista(el1),
    .DatoSalida(q1), .Desborde(d1), .SalidaValida(sv1), .SalidaLista(sl[1]));
  decodificador_bcd_secuencial #(.ANCHO_ENTRADA(8), .NUM_DIGITOS(2), .SUPRIMIR_CEROS(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .DatoEntrada(din[2]), .EntradaValida(ev[2]), .EntradaLista(el2),
    .DatoSalida(q2), .Desborde(d2), .SalidaValida(sv2), .SalidaLista(sl[2]));
  decodificador_bcd_secuencial #(.ANCHO_ENTRADA(8), .NUM_DIGITOS(3), .SUPRIMIR_CEROS(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .DatoEntrada(din[3]), .EntradaValida(ev[3]), .EntradaLista(el3),
    .DatoSalida(q3), .Desborde(d3), .SalidaValida(sv3), .SalidaLista(sl[3]));

  assign dout[0] = q0;
  assign dout[1] = {4'h0, q1};
  assign dout[2] = {4'h0, q2};
  assign dout[3] = q3;
  assign desb[0] = d0;
  assign desb[1] = d1;
  assign desb[2] = d2;
  assign desb[3] = d3;
  assign el[0] = el0;
  assign el[1] = el1;
  assign el[2] = el2;
  assign el[3] = el3;
  assign sv[0] = sv0;
  assign sv[1] = sv1;
  assign sv[2] = sv2;
  assign sv[3] = sv3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wk(input int k);
    return (k == 1) ? 4 : 8;
  endfunction

  function automatic int ndk(input int k);
    return (k == 0 || k == 3) ? 3 : 2;
  endfunction

  function automatic int pow10(input int nd);
    int p;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digits of (value mod 10^nd), leading zeros replaced by F when blanking.
  function automatic logic [11:0] ref_q(input int val, input int nd, input bit blank);
    int m;
    int dig [3];
    logic [11:0] r;
    bit todo_cero;
    m = val % pow10(nd);
    r = '0;
    for (int i = 0; i < 3; i++) dig[i] = 0;
    for (int i = 0; i < nd; i++) begin
      dig[i] = m % 10;
      m = m / 10;
    end
    todo_cero = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      if (blank && todo_cero && i > 0 && dig[i] == 0) r[4*i +: 4] = 4'hF;
      else begin
        todo_cero = 1'b0;
        r[4*i +: 4] = 4'(dig[i]);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Starts and ends on a falling edge; lat counts rising edges from acceptance to SalidaValida.
  task automatic do_conv(input int k, input int val, input int hold,
                         output logic [11:0] q, output logic d, output int lat);
    int n;
    n = 0;
    while (el[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_timeout_k%0d", k), 32'(n < 200), 32'd1);
    din[k] = 8'(val);
    ev[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev[k] = 1'b0;
    lat = 0;
    while (sv[k] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q = dout[k];
    d = desb[k];
    repeat (hold) @(negedge clk);
    sl[k] = 1'b1;
    @(negedge clk);
    sl[k] = 1'b0;
  endtask

  typedef struct {
    int         k;
    int         val;
    logic [11:0] q;
    logic       d;
  } vec_t;

  vec_t tabla[$];

  initial begin
    logic [11:0] q;
    logic        d;
    int          lat;
    bit          ok;
    int          val;

    tabla.push_back('{0, 0,   12'h000, 1'b0});
    tabla.push_back('{0, 255, 12'h255, 1'b0});
    tabla.push_back('{2, 123, 12'h023, 1'b1});
    tabla.push_back('{2, 99,  12'h099, 1'b0});
    tabla.push_back('{2, 100, 12'h000, 1'b1});
    tabla.push_back('{3, 7,   12'hFF7, 1'b0});
    tabla.push_back('{3, 0,   12'hFF0, 1'b0});
    tabla.push_back('{3, 105, 12'h105, 1'b0});
    tabla.push_back('{3, 10,  12'hF10, 1'b0});
    for (int v = 0; v < 16; v++)
      tabla.push_back('{1, v, 12'((v / 10) * 16 + (v % 10)), 1'b0});

    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din[k] = '0;
      ev[k]  = 1'b0;
      sl[k]  = 1'b0;
    end
    #3 rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_el_k%0d", k),   32'(el[k]),   32'd1);
      check($sformatf("reset_sv_k%0d", k),   32'(sv[k]),   32'd0);
      check($sformatf("reset_dout_k%0d", k), 32'(dout[k]), 32'd0);
      check($sformatf("reset_desb_k%0d", k), 32'(desb[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tabla[i]) begin
      do_conv(tabla[i].k, tabla[i].val, 0, q, d, lat);
      check($sformatf("tab%0d_k%0d_v%0d_q", i, tabla[i].k, tabla[i].val), 32'(q), 32'(tabla[i].q));
      check($sformatf("tab%0d_k%0d_v%0d_ovf", i, tabla[i].k, tabla[i].val), 32'(d), 32'(tabla[i].d));
      check($sformatf("tab%0d_k%0d_lat", i, tabla[i].k), 32'(lat), 32'(wk(tabla[i].k)));
    end

    // Back-pressure: result 77 held while a new value 42 waits upstream.
    while (el[0] !== 1'b1) @(negedge clk);
    din[0] = 8'd77;
    ev[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev[0] = 1'b0;
    lat = 0;
    while (sv[0] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_first_q", 32'(dout[0]), 32'h077);
    din[0] = 8'd42;
    ev[0] = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dout[0] !== 12'h077 || el[0] !== 1'b0 || sv[0] !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", 32'(ok), 32'd1);
    sl[0] = 1'b1;
    @(negedge clk);
    sl[0] = 1'b0;
    check("bp_release_el", 32'(el[0]), 32'd1);
    check("bp_release_sv", 32'(sv[0]), 32'd0);
    @(negedge clk);
    ev[0] = 1'b0;
    check("bp_accepted_el", 32'(el[0]), 32'd0);
    lat = 0;
    while (sv[0] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_42_lat", 32'(lat), 32'd8);
    check("bp_42_q", 32'(dout[0]), 32'h042);
    check("bp_42_ovf", 32'(desb[0]), 32'd0);
    sl[0] = 1'b1;
    @(negedge clk);
    sl[0] = 1'b0;

    // Asynchronous reset after the fourth shift of 200.
    din[0] = 8'd200;
    ev[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy", 32'(el[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_el", 32'(el[0]), 32'd1);
    check("rst_mid_sv", 32'(sv[0]), 32'd0);
    check("rst_mid_dout", 32'(dout[0]), 32'd0);
    check("rst_mid_desb", 32'(desb[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (sv[0] !== 1'b0) ok = 1'b0;
    end
    check("rst_mid_no_valid", 32'(ok), 32'd1);
    do_conv(0, 200, 0, q, d, lat);
    check("rst_after_q", 32'(q), 32'h200);
    check("rst_after_lat", 32'(lat), 32'd8);

    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 25; n++) begin
        val = int'($urandom_range(0, (1 << wk(k)) - 1));
        do_conv(k, val, int'($urandom_range(0, 3)), q, d, lat);
        check($sformatf("rnd_k%0d_v%0d_q", k, val), 32'(q), 32'(ref_q(val, ndk(k), k == 3)));
        check($sformatf("rnd_k%0d_v%0d_ovf", k, val), 32'(d), 32'(val >= pow10(ndk(k))));
        check($sformatf("rnd_k%0d_lat", k), 32'(lat), 32'(wk(k)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
